// File: rtl/exec_ctrl.sv
// Execution controller for the 4-bit CPU: turns button requests and a PC breakpoint
// into a registered one-cycle datapath enable, plus a saturating executed-instruction count.
module exec_ctrl #(
    parameter int DIV   = 50_000_000,
    parameter int DIV_W = 26,
    parameter int AW    = 4,
    parameter int CYC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_btn,
    input  logic             stop_btn,
    input  logic             step_btn,
    input  logic             bp_en,
    input  logic [AW-1:0]    bp_addr,
    input  logic [AW-1:0]    pc,
    output logic             ce,
    output logic [1:0]       state,
    output logic             halted,
    output logic [CYC_W-1:0] cycle_cnt
);

    // ce is a plain one-cycle strobe: no ready/back-pressure, the datapath must
    // consume it in the cycle it is high.
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_STEP  = 2'b10,
        S_BREAK = 2'b11
    } state_t;

    state_t cur_state, nxt_state;

    logic [2:0] btn_raw, btn_s1, btn_s2, btn_hist, btn_p;
    logic       start_p, stop_p, step_p;

    logic [DIV_W-1:0] presc;
    logic             tick;
    logic             skip_bp, skip_nxt;
    logic             ce_nxt;

    assign btn_raw = {start_btn, stop_btn, step_btn};
    assign btn_p   = btn_s2 & ~btn_hist;
    assign start_p = btn_p[2];
    assign stop_p  = btn_p[1];
    assign step_p  = btn_p[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_s1   <= '0;
            btn_s2   <= '0;
            btn_hist <= '0;
        end else begin
            btn_s1   <= btn_raw;
            btn_s2   <= btn_s1;
            btn_hist <= btn_s2;
        end
    end

    assign tick = (presc == DIV_W'(DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (cur_state == S_RUN) begin
            presc <= tick ? '0 : presc + DIV_W'(1);
        end else begin
            presc <= '0;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        ce_nxt    = 1'b0;
        skip_nxt  = skip_bp;
        case (cur_state)
            S_IDLE: begin
                // stop_p wins but does nothing here, so it also swallows start/step
                if (!stop_p) begin
                    if (start_p) begin
                        nxt_state = S_RUN;
                        skip_nxt  = 1'b0;
                    end else if (step_p) begin
                        nxt_state = S_STEP;
                    end
                end
            end
            S_RUN: begin
                if (stop_p) begin
                    nxt_state = S_IDLE;
                end else if (tick) begin
                    if (bp_en && (pc == bp_addr) && !skip_bp) begin
                        nxt_state = S_BREAK;
                    end else begin
                        ce_nxt   = 1'b1;
                        skip_nxt = 1'b0;
                    end
                end
            end
            S_STEP: begin
                ce_nxt    = 1'b1;
                nxt_state = S_IDLE;
            end
            S_BREAK: begin
                if (stop_p) begin
                    nxt_state = S_IDLE;
                end else if (start_p) begin
                    // let the instruction sitting at the breakpoint execute once
                    nxt_state = S_RUN;
                    skip_nxt  = 1'b1;
                end else if (step_p) begin
                    nxt_state = S_STEP;
                end
            end
            default: nxt_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= S_IDLE;
            ce        <= 1'b0;
            skip_bp   <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            ce        <= ce_nxt;
            skip_bp   <= skip_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt <= '0;
        end else if (ce && (cycle_cnt != '1)) begin
            cycle_cnt <= cycle_cnt + CYC_W'(1);
        end
    end

    assign state  = cur_state;
    assign halted = (cur_state == S_IDLE) || (cur_state == S_BREAK);

endmodule
